// File: rtl/vga_draw_arbiter_pkg.sv
// ============================================================================
// vga_draw_arbiter_pkg : screen geometry, colours and arbiter FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_draw_arbiter_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic on_screen(input int unsigned px, input int unsigned py);
        return (px < SCREEN_W) && (py < SCREEN_H);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_draw_arbiter_square_scanner.sv
// ============================================================================
// vga_draw_arbiter_square_scanner : raster walk over a (side+1)^2 square
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_draw_arbiter_square_scanner #(
    parameter int SIDE_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SIDE_W-1:0] side,
    output logic [SIDE_W-1:0] dx,
    output logic [SIDE_W-1:0] dy,
    output logic              last
);

    logic [SIDE_W-1:0] side_l;

    // Free-runs after start; the owner ignores the offsets outside its scan window.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dx     <= '0;
            dy     <= '0;
            side_l <= '0;
        end else if (start) begin
            dx     <= '0;
            dy     <= '0;
            side_l <= side;
        end else if (dx == side_l) begin
            dx <= '0;
            dy <= dy + 1'b1;
        end else begin
            dx <= dx + 1'b1;
        end
    end

    assign last = (dx == side_l) && (dy == side_l);

endmodule

`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
// ============================================================================
// vga_draw_arbiter : round-robin sharing of the VGA write port among square drawers
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SIDE_W   = 5,
    parameter int COLOUR_W = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*SIDE_W-1:0]    req_side,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot
);

    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_next;
    logic [IDX_W-1:0]     ptr, sel, pick, off;
    logic [NUM_REQ-1:0]   rot, sel_oh;
    logic [X_W-1:0]       x0;
    logic [Y_W-1:0]       y0;
    logic [COLOUR_W-1:0]  colour_l;
    logic [SIDE_W-1:0]    dx, dy;
    logic                 last;
    logic [X_W:0]         sum_x;
    logic [Y_W:0]         sum_y;

    logic [NUM_REQ-1:0]   grant_nx, done_nx;
    logic                 busy_nx, plot_nx;
    logic [X_W-1:0]       x_nx;
    logic [Y_W-1:0]       y_nx;
    logic [COLOUR_W-1:0]  colour_nx;

    logic [X_W-1:0]       fx [NUM_REQ];
    logic [Y_W-1:0]       fy [NUM_REQ];
    logic [SIDE_W-1:0]    fs [NUM_REQ];
    logic [COLOUR_W-1:0]  fc [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign fx[i] = req_x[i*X_W +: X_W];
        assign fy[i] = req_y[i*Y_W +: Y_W];
        assign fs[i] = req_side[i*SIDE_W +: SIDE_W];
        assign fc[i] = req_colour[i*COLOUR_W +: COLOUR_W];
    end

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(NUM_REQ))
            s = s - (IDX_W+1)'(NUM_REQ);
        return s[IDX_W-1:0];
    endfunction

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner.
    assign rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k])
                off = IDX_W'(k);
        end
    end

    assign pick   = wrap_add(ptr, off);
    assign sel_oh = NUM_REQ'(1) << sel;
    assign sum_x  = {1'b0, x0} + (X_W+1)'(dx);
    assign sum_y  = {1'b0, y0} + (Y_W+1)'(dy);

    vga_draw_arbiter_square_scanner #(
        .SIDE_W (SIDE_W)
    ) u_scanner (
        .clock (clock),
        .reset (reset),
        .start (state == ST_LATCH),
        .side  (fs[sel]),
        .dx    (dx),
        .dy    (dy),
        .last  (last)
    );

    always_comb begin
        state_next = state;
        grant_nx   = '0;
        done_nx    = '0;
        busy_nx    = 1'b0;
        plot_nx    = 1'b0;
        x_nx       = x;
        y_nx       = y;
        colour_nx  = colour;
        case (state)
            ST_IDLE: begin
                if (|req)
                    state_next = ST_LATCH;
            end
            ST_LATCH: begin
                grant_nx   = sel_oh;
                busy_nx    = 1'b1;
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                grant_nx  = sel_oh;
                busy_nx   = 1'b1;
                // Clip on the unwrapped sum so coordinates past the field width never alias on-screen.
                plot_nx   = on_screen(32'(sum_x), 32'(sum_y));
                x_nx      = sum_x[X_W-1:0];
                y_nx      = sum_y[Y_W-1:0];
                colour_nx = colour_l;
                if (last)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                grant_nx   = sel_oh;
                done_nx    = sel_oh;
                busy_nx    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            x0       <= '0;
            y0       <= '0;
            colour_l <= '0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= COLOUR_W'(BLACK);
        end else begin
            state  <= state_next;
            grant  <= grant_nx;
            done   <= done_nx;
            busy   <= busy_nx;
            plot   <= plot_nx;
            x      <= x_nx;
            y      <= y_nx;
            colour <= colour_nx;
            if (state == ST_IDLE && (|req))
                sel <= pick;
            if (state == ST_LATCH) begin
                x0       <= fx[sel];
                y0       <= fy[sel];
                colour_l <= fc[sel];
            end
            if (state == ST_DONE)
                ptr <= wrap_add(sel, IDX_W'(1));
        end
    end

endmodule

`default_nettype wire
